// File: rtl/serial_register_reader_if.sv
// Handshake/bus bundle for serial_register_reader.
//   load_req/data_in/load_ack : snapshot request side
//   out_bit/out_valid/out_ready/out_last : serial stream side
//   busy : reader is streaming a frame
// Modports: slave = the reader itself, master = whoever drives requests and
// consumes the stream.
interface serial_register_reader_if #(
  parameter int WIDTH = 8
);
  logic             load_req;
  logic [WIDTH-1:0] data_in;
  logic             load_ack;
  logic             busy;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  load_req, data_in, out_ready,
    output load_ack, busy, out_bit, out_valid, out_last
  );

  modport master (
    output load_req, data_in, out_ready,
    input  load_ack, busy, out_bit, out_valid, out_last
  );
endinterface

// File: rtl/serial_register_reader.sv
// serial_register_reader
// Snapshots a WIDTH-bit parallel register on request and streams it out one
// bit per beat, LSB first, over a valid/ready handshake. The upstream register
// is free again as soon as load_ack pulses.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : serial_register_reader_if.slave (load_req, data_in, load_ack,
//           busy, out_bit, out_valid, out_ready, out_last)
//
// Build option: SERIAL_READER_PARITY_EN appends an even-parity beat (XOR of
// the snapshot) after the WIDTH data beats; out_last then marks that beat.
//
// state | meaning
// IDLE  | waiting for load_req; all outputs low
// SHIFT | offering shreg[0]; advances on out_valid & out_ready
module serial_register_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input logic                     clk,
  input logic                     reset,
  serial_register_reader_if.slave bus
);

`ifdef SERIAL_READER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [BEATS-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             load_ack_q;
  logic             in_shift;
  logic             last_beat;
  logic             load_fire;
  logic             beat_fire;

  assign in_shift  = (state == SHIFT);
  assign last_beat = in_shift && (cnt == LAST_CNT);
  assign load_fire = (state == IDLE) && bus.load_req;
  assign beat_fire = in_shift && bus.out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load_req) state_nxt = SHIFT;
      SHIFT:   if (bus.out_ready && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Parity (when enabled) rides in the top bit of the shift register so the
  // extra beat falls out of the normal right shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      cnt        <= '0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= load_fire;
      if (load_fire) begin
`ifdef SERIAL_READER_PARITY_EN
        shreg <= {^bus.data_in, bus.data_in};
`else
        shreg <= bus.data_in;
`endif
        cnt   <= '0;
      end else if (beat_fire) begin
        shreg <= {1'b0, shreg[BEATS-1:1]};
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // Outputs decode straight from registered state so an async reset drops
  // them without waiting for an edge.
  assign bus.load_ack  = load_ack_q;
  assign bus.busy      = in_shift;
  assign bus.out_valid = in_shift;
  assign bus.out_bit   = in_shift & shreg[0];
  assign bus.out_last  = last_beat;

endmodule

// File: tb/tb_serial_register_reader.sv
module tb_serial_register_reader;

  localparam int WIDTH = 8;
`ifdef SERIAL_READER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_register_reader_if #(.WIDTH(WIDTH)) sif ();

  serial_register_reader #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  typedef struct {
    string       nm;
    logic [7:0]  data;
    logic [63:0] rdy;
    int          inj;
    logic [8:0]  exp_stream;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference stream: data bits LSB first, then (optionally) even parity
  // derived by counting ones.
  function automatic logic [8:0] model_stream(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) if (d[i]) ones++;
    return {((ones % 2) == 1), d};
  endfunction

  task automatic check_idle(input string nm);
    chk({nm, "/busy"},  sif.busy,      1'b0);
    chk({nm, "/valid"}, sif.out_valid, 1'b0);
    chk({nm, "/last"},  sif.out_last,  1'b0);
    chk({nm, "/ack"},   sif.load_ack,  1'b0);
    chk({nm, "/bit"},   sif.out_bit,   1'b0);
  endtask

  // Called at the #1-after-edge point. Issues load_req, then consumes the
  // frame with the given ready pattern (one bit per cycle, 1 after 64
  // cycles). inj >= 0 fires a load_req with different data on that cycle.
  task automatic run_frame(input string nm, input logic [7:0] data,
                           input logic [63:0] rdy, input int inj,
                           input logic [8:0] exp_stream);
    int idx;
    int cyc;
    sif.load_req  = 1'b1;
    sif.data_in   = data;
    sif.out_ready = 1'b0;
    @(posedge clk); #1;
    sif.load_req = 1'b0;
    sif.data_in  = 8'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < BEATS && cyc < 200) begin
      sif.out_ready = (cyc < 64) ? rdy[cyc] : 1'b1;
      sif.load_req  = (cyc == inj);
      if (cyc == inj) sif.data_in = ~data;
      chk({nm, "/ack"},   sif.load_ack,  (cyc == 0));
      chk({nm, "/valid"}, sif.out_valid, 1'b1);
      chk({nm, "/busy"},  sif.busy,      1'b1);
      chk({nm, "/bit"},   sif.out_bit,   exp_stream[idx]);
      chk({nm, "/last"},  sif.out_last,  (idx == BEATS - 1));
      if (sif.out_ready) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    sif.load_req  = 1'b0;
    sif.out_ready = 1'b0;
    chk({nm, "/beats"}, idx, BEATS);
    check_idle({nm, "/end"});
  endtask

  initial begin
    vecs[0] = '{"a5",  8'hA5, 64'hFFFF_FFFF_FFFF_FFFF, -1, 9'h0A5};
    vecs[1] = '{"3c",  8'h3C, 64'hFFFF_FFFF_FFFF_FFE9, -1, 9'h03C};
    vecs[2] = '{"f0",  8'hF0, 64'hFFFF_FFFF_FFFF_FFFF,  3, 9'h0F0};
    vecs[3] = '{"0f",  8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, -1, 9'h00F};
    vecs[4] = '{"07",  8'h07, 64'hFFFF_FFFF_FFFF_5555, -1, 9'h107};
    vecs[5] = '{"00",  8'h00, 64'hFFFF_FFFF_FFFF_FF0F,  0, 9'h000};
    vecs[6] = '{"01",  8'h01, 64'hFFFF_FFFF_FFFF_FFFF,  7, 9'h101};

    sif.load_req  = 1'b0;
    sif.data_in   = '0;
    sif.out_ready = 1'b0;

    // Power-up: held in reset for 3 cycles, even with a request pending.
    repeat (3) @(posedge clk);
    #1;
    sif.load_req = 1'b1;
    @(posedge clk); #1;
    check_idle("por");
    sif.load_req = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("idle");
    end

    // Directed frames, back-to-back (minimum turnaround).
    for (int v = 0; v < 7; v++)
      run_frame(vecs[v].nm, vecs[v].data, vecs[v].rdy, vecs[v].inj, vecs[v].exp_stream);

    // Reset mid-frame: 3 beats out, then async reset between edges.
    sif.load_req = 1'b1;
    sif.data_in  = 8'hFF;
    @(posedge clk); #1;
    sif.load_req  = 1'b0;
    sif.out_ready = 1'b1;
    chk("rst/ack", sif.load_ack, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst/pre_valid", sif.out_valid, 1'b1);
    chk("rst/pre_bit",   sif.out_bit,   1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("rst/async");
    sif.load_req = 1'b1;
    @(posedge clk); #1;
    check_idle("rst/held");
    sif.load_req  = 1'b0;
    sif.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle("rst/released");
    run_frame("81", 8'h81, 64'hFFFF_FFFF_FFFF_FFFF, -1, 9'h081);

    // Randomized frames against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0]  d;
      logic [63:0] r;
      int          inj;
      d   = 8'($urandom);
      r   = {$urandom, $urandom};
      inj = int'($urandom_range(0, 14)) - 3;
      run_frame("rnd", d, r, inj, model_stream(d));
      if (($urandom & 1) == 1) begin
        @(posedge clk); #1;
        check_idle("rnd/gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
